movegen_sequencer: RTL and testbench

//  Control FSM for the pseudo-legal board. It walks the move token from square to square.
//  For each token holder it takes the multi-hot target set, picks targets lowest-index-first,

---
 rtl/movegen_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_movegen_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/movegen_sequencer.sv
// Move-generation sequencer: walks the token across the board, expands each
// holder's target set lowest-index-first, looks up the captured piece and
// streams 20-bit UCI moves as one SOP/EOP packet through a 1-entry hold buffer.
module movegen_sequencer #(
  parameter int LOOKUP_LAT   = 1,
  parameter int TOKEN_SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        board_loaded,
  input  logic        in_wtp,
  input  logic [63:0] sq_from,
  input  logic [2:0]  sq_from_piece,
  input  logic [63:0] sq_to,
  output logic        token_next,
  output logic [5:0]  lookup_rankfile,
  input  logic [2:0]  lookup_piece,
  output logic        o_uci_valid,
  output logic [19:0] o_uci_data,
  output logic        o_uci_sop,
  output logic        o_uci_eop,
  input  logic        o_uci_ready,
  output logic        busy,
  output logic        err_multi_token
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_PICK,
    S_LOOKUP,
    S_PUSH,
    S_FLUSH
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt;
  logic [63:0] pending;
  logic [5:0]  from_idx;
  logic [2:0]  from_piece;
  logic [2:0]  taken;
  logic        promo;
  logic [1:0]  prom_cnt;
  logic        hold_full;
  logic        hold_sop;
  logic        first_beat;
  logic [19:0] hold_data;

  logic        settle_done;
  logic        lookup_done;
  logic        push_ok;
  logic        last_variant;
  logic [19:0] new_move;
  logic [2:0]  prom_rank;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [5:0] lowest_bit(input logic [63:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) r = 6'(i);
    end
    return r;
  endfunction

  assign settle_done  = (cnt == 2'(TOKEN_SETTLE - 1));
  assign lookup_done  = (cnt == 2'(LOOKUP_LAT));
  assign push_ok      = (state == S_PUSH) && (!hold_full || o_uci_ready);
  assign last_variant = !promo || (prom_cnt == 2'd3);
  assign new_move     = {(promo ? prom_cnt : 2'b00), from_piece, from_idx, taken, lookup_rankfile};
  assign prom_rank    = in_wtp ? 3'd7 : 3'd0;
  assign busy         = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and stream/token handshake outputs.
  always_comb begin
    state_nx    = state;
    token_next  = 1'b0;
    o_uci_valid = 1'b0;
    o_uci_sop   = 1'b0;
    o_uci_eop   = 1'b0;
    o_uci_data  = '0;
    case (state)
      S_IDLE: begin
        if (start && board_loaded) state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_done) state_nx = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (sq_from == '0) state_nx = S_FLUSH;
        else               state_nx = S_PICK;
      end
      S_PICK: begin
        if (pending == '0) begin
          token_next = 1'b1;
          state_nx   = S_SETTLE;
        end else begin
          state_nx   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_done) state_nx = S_PUSH;
      end
      S_PUSH: begin
        o_uci_valid = hold_full;
        o_uci_sop   = hold_full & hold_sop;
        o_uci_data  = hold_full ? hold_data : '0;
        if (push_ok && last_variant) state_nx = S_PICK;
      end
      S_FLUSH: begin
        o_uci_valid = 1'b1;
        o_uci_sop   = hold_full ? hold_sop : 1'b1;
        o_uci_eop   = 1'b1;
        o_uci_data  = hold_full ? hold_data : '0;
        if (o_uci_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Control state: counters, pending mask, hold-buffer flags, error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      pending         <= '0;
      lookup_rankfile <= '0;
      promo           <= 1'b0;
      prom_cnt        <= '0;
      hold_full       <= 1'b0;
      hold_sop        <= 1'b0;
      first_beat      <= 1'b0;
      err_multi_token <= 1'b0;
    end else begin
      cnt <= (state_nx == state) ? cnt + 2'd1 : 2'd0;
      case (state)
        S_IDLE: begin
          if (start && board_loaded) first_beat <= 1'b1;
        end
        S_SAMPLE: begin
          if (sq_from != '0) begin
            pending <= sq_to;
            if ((sq_from & (sq_from - 64'd1)) != '0) err_multi_token <= 1'b1;
          end
        end
        S_PICK: begin
          if (pending != '0) begin
            lookup_rankfile <= lowest_bit(pending);
            pending         <= pending & (pending - 64'd1);
          end
        end
        S_LOOKUP: begin
          if (lookup_done) begin
            promo    <= (from_piece == 3'd6) && (lookup_rankfile[5:3] == prom_rank);
            prom_cnt <= '0;
          end
        end
        S_PUSH: begin
          if (push_ok) begin
            hold_full  <= 1'b1;
            hold_sop   <= first_beat;
            first_beat <= 1'b0;
            prom_cnt   <= prom_cnt + 2'd1;
          end
        end
        S_FLUSH: begin
          if (o_uci_ready) hold_full <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath captures: token holder, looked-up piece, held move.
  always_ff @(posedge clk) begin
    if (state == S_SAMPLE) begin
      from_idx   <= lowest_bit(sq_from);
      from_piece <= sq_from_piece;
    end
    if (state == S_LOOKUP && lookup_done) taken <= lookup_piece;
    if (push_ok) hold_data <= new_move;
  end

endmodule

// File: tb/tb_movegen_sequencer.sv
// Scoreboard bench for movegen_sequencer: directed boards, a token-walk model,
// a latency-accurate lookup RAM model and a decoupled output monitor.
module tb_movegen_sequencer;
  localparam int LAT    = 2;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst, start, board_loaded, in_wtp;
  logic [63:0] sq_from, sq_to;
  logic [2:0]  sq_from_piece, lookup_piece;
  logic        token_next;
  logic [5:0]  lookup_rankfile;
  logic        o_uci_valid, o_uci_sop, o_uci_eop, o_uci_ready;
  logic [19:0] o_uci_data;
  logic        busy, err_multi_token;

  int errors = 0;
  int checks = 0;

  logic [63:0] h_mask [4];
  logic [2:0]  h_pc   [4];
  logic [63:0] h_to   [4];
  int          n_h = 0;
  int          tok_cnt = 0;
  int          tok_base = 0;
  int          hk;
  logic [2:0]  board_pc [64];
  logic [2:0]  lk_pipe  [LAT];
  logic [21:0] sb [$];
  logic        prev_stall;
  logic [21:0] prev_beat;

  movegen_sequencer #(.LOOKUP_LAT(LAT), .TOKEN_SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .board_loaded(board_loaded), .in_wtp(in_wtp),
    .sq_from(sq_from), .sq_from_piece(sq_from_piece), .sq_to(sq_to),
    .token_next(token_next), .lookup_rankfile(lookup_rankfile), .lookup_piece(lookup_piece),
    .o_uci_valid(o_uci_valid), .o_uci_data(o_uci_data), .o_uci_sop(o_uci_sop),
    .o_uci_eop(o_uci_eop), .o_uci_ready(o_uci_ready), .busy(busy),
    .err_multi_token(err_multi_token)
  );

  always #5 clk = ~clk;

  // Token holders presented to the sequencer as the token walks.
  always_comb begin
    sq_from       = '0;
    sq_from_piece = '0;
    sq_to         = '0;
    hk            = tok_cnt - tok_base;
    if (hk >= 0 && hk < n_h) begin
      sq_from       = h_mask[hk[1:0]];
      sq_from_piece = h_pc[hk[1:0]];
      sq_to         = h_to[hk[1:0]];
    end
  end

  // Target-piece RAM with LAT cycles of read latency.
  always @(posedge clk) begin
    lk_pipe[0] <= board_pc[lookup_rankfile];
    for (int i = 1; i < LAT; i++) lk_pipe[i] <= lk_pipe[i-1];
  end
  assign lookup_piece = lk_pipe[LAT-1];

  // Token advance model.
  initial begin
    forever begin
      @(negedge clk);
      if (token_next === 1'b1) tok_cnt++;
    end
  end

  // Output monitor: pops expected beats, checks stall stability and token quiet.
  initial begin
    logic [21:0] got, exp;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      got = {o_uci_sop, o_uci_eop, o_uci_data};
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!(o_uci_valid === 1'b1 && got === prev_beat)) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b beat=%h want v=1 beat=%h", o_uci_valid, got, prev_beat);
          end
        end
        if (o_uci_valid && !o_uci_ready) begin
          checks++;
          if (token_next !== 1'b0) begin
            errors++;
            $display("FAIL stall_token: got token_next=%0b want 0", token_next);
          end
        end
        if (o_uci_valid && o_uci_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got %h want none", got);
          end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL beat: got sop/eop/data=%h want %h", got, exp);
            end
          end
        end
        prev_stall = o_uci_valid && !o_uci_ready;
        prev_beat  = got;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] mk(input logic [1:0] p, input logic [2:0] mv, input logic [5:0] fr,
                                     input logic [2:0] tk, input logic [5:0] to);
    return {p, mv, fr, tk, to};
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic exp_beat(input logic sop, input logic eop, input logic [19:0] d);
    sb.push_back({sop, eop, d});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_pkt(input string nm, input int exp_tok);
    logic ok;
    pulse_start();
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk({nm, "_done"}, 64'(ok), 64'd1);
    chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
    chk({nm, "_tokens"}, 64'(tok_cnt - tok_base), 64'(exp_tok));
  endtask

  task automatic setup_knight();
    tok_base = tok_cnt;
    n_h = 1;
    h_mask[0] = 64'd1 << 1; h_pc[0] = 3'd5;
    h_to[0] = (64'd1 << 16) | (64'd1 << 18) | (64'd1 << 11);
    exp_beat(1'b1, 1'b0, mk(2'd0, 3'd5, 6'd1, 3'd0, 6'd11));
    exp_beat(1'b0, 1'b0, mk(2'd0, 3'd5, 6'd1, 3'd0, 6'd16));
    exp_beat(1'b0, 1'b1, mk(2'd0, 3'd5, 6'd1, 3'd0, 6'd18));
  endtask

  task automatic setup_pawn(input logic promo_exp);
    tok_base = tok_cnt;
    n_h = 1;
    h_mask[0] = 64'd1 << 52; h_pc[0] = 3'd6; h_to[0] = 64'd1 << 60;
    if (promo_exp) begin
      for (int p = 0; p < 4; p++)
        exp_beat(p == 0, p == 3, mk(2'(p), 3'd6, 6'd52, 3'd0, 6'd60));
    end else begin
      exp_beat(1'b1, 1'b1, mk(2'd0, 3'd6, 6'd52, 3'd0, 6'd60));
    end
  endtask

  initial begin
    logic ok2;
    rst = 1'b1; start = 1'b0; board_loaded = 1'b1; in_wtp = 1'b1; o_uci_ready = 1'b1;
    for (int i = 0; i < 64; i++) board_pc[i] = 3'd0;
    for (int i = 0; i < 4; i++) begin h_mask[i] = '0; h_pc[i] = '0; h_to[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(o_uci_valid), 64'd0);
    chk("rst_sop", 64'(o_uci_sop), 64'd0);
    chk("rst_eop", 64'(o_uci_eop), 64'd0);
    chk("rst_data", 64'(o_uci_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_token", 64'(token_next), 64'd0);
    chk("rst_err", 64'(err_multi_token), 64'd0);
    chk("rst_rankfile", 64'(lookup_rankfile), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    setup_knight();
    run_pkt("knight", 1);

    tok_base = tok_cnt; n_h = 0;
    exp_beat(1'b1, 1'b1, 20'd0);
    run_pkt("null", 0);

    setup_pawn(1'b1);
    run_pkt("promo_white", 1);

    in_wtp = 1'b0;
    setup_pawn(1'b0);
    run_pkt("no_promo_black", 1);
    in_wtp = 1'b1;

    setup_knight();
    o_uci_ready = 1'b0;
    fork
      run_pkt("stall", 1);
      begin
        ok2 = 1'b0;
        for (int n = 0; n < 500; n++) begin
          @(negedge clk);
          if (o_uci_valid) begin ok2 = 1'b1; break; end
        end
        chk("stall_seen", 64'(ok2), 64'd1);
        repeat (10) @(negedge clk);
        @(posedge clk); #1 o_uci_ready = 1'b1;
      end
    join
    o_uci_ready = 1'b1;

    tok_base = tok_cnt; n_h = 1;
    h_mask[0] = 64'd1; h_pc[0] = 3'd3; h_to[0] = (64'd1 << 8) | (64'd1 << 56);
    board_pc[56] = 3'd4;
    exp_beat(1'b1, 1'b0, mk(2'd0, 3'd3, 6'd0, 3'd0, 6'd8));
    exp_beat(1'b0, 1'b1, mk(2'd0, 3'd3, 6'd0, 3'd4, 6'd56));
    run_pkt("capture", 1);
    board_pc[56] = 3'd0;

    chk("err_before_multi", 64'(err_multi_token), 64'd0);
    tok_base = tok_cnt; n_h = 2;
    h_mask[0] = (64'd1 << 9) | (64'd1 << 12); h_pc[0] = 3'd2; h_to[0] = 64'd1 << 17;
    h_mask[1] = 64'd1 << 20; h_pc[1] = 3'd1; h_to[1] = '0;
    exp_beat(1'b1, 1'b1, mk(2'd0, 3'd2, 6'd9, 3'd0, 6'd17));
    run_pkt("multi", 2);
    chk("multi_err", 64'(err_multi_token), 64'd1);

    board_loaded = 1'b0;
    tok_base = tok_cnt; n_h = 0;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("noload_busy", 64'(busy), 64'd0);
    chk("noload_valid", 64'(o_uci_valid), 64'd0);
    board_loaded = 1'b1;

    setup_pawn(1'b1);
    o_uci_ready = 1'b0;
    pulse_start();
    ok2 = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (o_uci_valid) begin ok2 = 1'b1; break; end
    end
    chk("rstmid_seen", 64'(ok2), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_valid", 64'(o_uci_valid), 64'd0);
    chk("rstmid_sop", 64'(o_uci_sop), 64'd0);
    chk("rstmid_eop", 64'(o_uci_eop), 64'd0);
    chk("rstmid_data", 64'(o_uci_data), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_token", 64'(token_next), 64'd0);
    chk("rstmid_err", 64'(err_multi_token), 64'd0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0; o_uci_ready = 1'b1;

    setup_knight();
    run_pkt("after_rst", 1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
